rvfi_ref_checker: RTL
=====================

// Module: rvfi_ref_checker
// PURPOSE
//  Consumer side of the ISS step/interrupt interface. Buffers core RVFI
//  retirements and requests one reference-model step per retirement.
//  Injects pending interrupts before the trap-handler step, then compares
//  the returned reference retirement field-by-field. Sits in the formal and
//  simulation harness between the core RVFI tracer and the reference model.
// PARAMETERS
//  DEPTH    4   core retirement FIFO entries (power of 2, >=2)
//  XLEN     32  register/PC width
//  MAX_LAG  64  max cycles waiting for ref_valid_i after a step request
// PORTS
//  clk_i            in   1      clock
//  rst_i            in   1      async reset, active-high
//  core_valid_i     in   1      core retirement valid (no backpressure)
//  core_order_i     in   64     retirement order
//  core_pc_i        in   XLEN   pc_rdata
//  core_insn_i      in   32     instruction word
//  core_rd_addr_i   in   5      destination register
//  core_rd_wdata_i  in   XLEN   destination write data
//  core_trap_i      in   1      trap flag
//  core_intr_i      in   1      first instruction of interrupt handler
//  core_irq_i       in   32     irq vector, captured with the retirement
//  ref_step_o       out  1      1-cycle pulse: ref model steps one instruction
//  ref_intr_o       out  1      1-cycle pulse: apply ref_irq_o to ref mip
//  ref_irq_o        out  32     irq vector, valid while ref_intr_o=1
//  ref_valid_i      in   1      ref retirement valid
//  ref_ready_o      out  1      checker accepts ref retirement
//  ref_pc_i/ref_insn_i/ref_rd_addr_i/ref_rd_wdata_i/ref_trap_i  in  as core
//  mismatch_o       out  1      sticky: compare failed
//  mismatch_mask_o  out  5      sticky {trap,rd_wdata,rd_addr,insn,pc}
//  err_order_o      out  1      sticky: head order != expected
//  overflow_o       out  1      sticky: push while full without a pop
//  timeout_o        out  1      sticky: ref did not answer in MAX_LAG
//  compared_cnt_o   out  32     passing compares, wraps at 2^32
//  fifo_level_o     out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, expected order=0.
//  FIFO push: core_valid_i && (!full || pop this cycle) && state!=ERROR.
//   If full with no pop: entry dropped, overflow_o set, FSM -> ERROR.
//  FSM states IDLE, INTR, STEP, WAIT, CMP, ERROR:
//   IDLE: FIFO non-empty -> check head order vs expected.
//    Mismatch: err_order_o set -> ERROR.
//    Match: head.intr -> INTR, else -> STEP.
//   INTR: ref_intr_o=1, ref_irq_o=head.irq for one cycle -> STEP.
//   STEP: ref_step_o=1 for one cycle; lag timer cleared -> WAIT.
//   WAIT: ref_ready_o=1; ref_valid_i captures ref fields -> CMP.
//    Timer reaches MAX_LAG-1 without ref_valid_i: timeout_o -> ERROR.
//   CMP: compare pc, insn, rd_addr, trap always; rd_wdata only if
//    rd_addr!=0. Pop head; expected order +=1.
//    Any diff: mismatch bits OR'd into mask, mismatch_o -> ERROR.
//    Else compared_cnt_o+=1 -> IDLE.
//   ERROR: terminal until rst_i; no step/intr pulses, ref_ready_o=0.
//  Latency: head ready in IDLE -> ref_step_o 1 cycle later (2 with intr);
//   ref_valid_i in WAIT -> result visible 1 cycle after CMP.
//  ref_valid_i outside WAIT: ignored, not an error.
//  Simultaneous push and pop at full: both occur, level unchanged.
//  Reset mid-operation: FSM, FIFO and counters cleared immediately.
//   An outstanding ref step is abandoned.
// TESTING
//  Retire order 0..3 (pc 0x80,0x84,..), ref echoes -> 4 step pulses,
//   compared_cnt_o=4, no flags.
//  Ref rd_wdata 0x5 vs core 0x6 at rd=x3 -> mismatch_o=1, mask=5'b01000;
//   same diff at rd=x0 -> no mismatch.
//  Retirement with core_intr_i=1, irq=0x800 -> ref_intr_o pulse with
//   ref_irq_o=0x800, then ref_step_o next cycle.
//  DEPTH=4: 5 back-to-back retirements, ref silent -> overflow_o=1, ERROR.
//  Step issued, ref silent for 64 cycles -> timeout_o=1; assert rst_i in
//   WAIT -> all outputs 0 next edge.
//  Core order sequence 0,1,3 -> err_order_o on order 3, compared_cnt_o=2.

Source files
------------

// File: rtl/rvfi_ref_checker_if.sv
// Signal bundle between the harness (core tracer + reference model) and the RVFI reference checker.
// The master side is the harness. The slave side is the checker.
interface rvfi_ref_checker_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   logic                     core_valid_i;
   logic [63:0]              core_order_i;
   logic [XLEN-1:0]          core_pc_i;
   logic [31:0]              core_insn_i;
   logic [4:0]               core_rd_addr_i;
   logic [XLEN-1:0]          core_rd_wdata_i;
   logic                     core_trap_i;
   logic                     core_intr_i;
   logic [31:0]              core_irq_i;
   logic                     ref_step_o;
   logic                     ref_intr_o;
   logic [31:0]              ref_irq_o;
   logic                     ref_valid_i;
   logic                     ref_ready_o;
   logic [XLEN-1:0]          ref_pc_i;
   logic [31:0]              ref_insn_i;
   logic [4:0]               ref_rd_addr_i;
   logic [XLEN-1:0]          ref_rd_wdata_i;
   logic                     ref_trap_i;
   logic                     mismatch_o;
   logic [4:0]               mismatch_mask_o;
   logic                     err_order_o;
   logic                     overflow_o;
   logic                     timeout_o;
   logic [31:0]              compared_cnt_o;
   logic [$clog2(DEPTH):0]   fifo_level_o;

   modport master (
      output core_valid_i, core_order_i, core_pc_i, core_insn_i, core_rd_addr_i,
             core_rd_wdata_i, core_trap_i, core_intr_i, core_irq_i,
             ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i, ref_rd_wdata_i, ref_trap_i,
      input  ref_step_o, ref_intr_o, ref_irq_o, ref_ready_o, mismatch_o, mismatch_mask_o,
             err_order_o, overflow_o, timeout_o, compared_cnt_o, fifo_level_o
   );

   modport slave (
      input  core_valid_i, core_order_i, core_pc_i, core_insn_i, core_rd_addr_i,
             core_rd_wdata_i, core_trap_i, core_intr_i, core_irq_i,
             ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i, ref_rd_wdata_i, ref_trap_i,
      output ref_step_o, ref_intr_o, ref_irq_o, ref_ready_o, mismatch_o, mismatch_mask_o,
             err_order_o, overflow_o, timeout_o, compared_cnt_o, fifo_level_o
   );
endinterface

// File: rtl/rvfi_ref_checker.sv
// Buffers core RVFI retirements, steps the reference model once per retirement
// (injecting interrupts first), and compares the reference retirement field by field.
//
//   state | meaning
//   IDLE  | waiting for a buffered retirement; checks its order
//   INTR  | pulse ref_intr_o with the head irq vector
//   STEP  | pulse ref_step_o; load the lag timer
//   WAIT  | ref_ready_o high; capture the ref retirement or time out
//   CMP   | compare head against the captured ref retirement; pop head
//   ERROR | terminal until reset; no pulses, not ready
module rvfi_ref_checker #(
   parameter int DEPTH   = 4,
   parameter int XLEN    = 32,
   parameter int MAX_LAG = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   rvfi_ref_checker_if.slave  rvfi
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(MAX_LAG);

   typedef enum logic [2:0] {IDLE, INTR, STEP, WAIT, CMP, ERROR} state_t;

   typedef struct packed {
      logic [63:0]     order;
      logic [XLEN-1:0] pc;
      logic [31:0]     insn;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic            trap;
      logic            intr;
      logic [31:0]     irq;
   } entry_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     insn;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic            trap;
   } ref_t;

   state_t          state, state_nxt;
   entry_t          mem [DEPTH];
   entry_t          head;
   entry_t          wr_entry;
   ref_t            ref_cap;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     level;
   logic [63:0]     exp_order;
   logic [LW-1:0]   lag;
   logic [4:0]      diff;
   logic            full, empty, push, pop, ovf;
   logic            set_err_order, set_timeout;
   logic            mismatch, err_order, overflow, timeout;
   logic [4:0]      mask;
   logic [31:0]     cnt;

   assign head  = mem[rd_ptr];
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign pop   = (state == CMP);
   assign push  = rvfi.core_valid_i && (!full || pop) && (state != ERROR);
   assign ovf   = rvfi.core_valid_i && full && !pop && (state != ERROR);

   assign wr_entry = '{order:    rvfi.core_order_i,
                       pc:       rvfi.core_pc_i,
                       insn:     rvfi.core_insn_i,
                       rd_addr:  rvfi.core_rd_addr_i,
                       rd_wdata: rvfi.core_rd_wdata_i,
                       trap:     rvfi.core_trap_i,
                       intr:     rvfi.core_intr_i,
                       irq:      rvfi.core_irq_i};

   // Writes to x0 carry no architectural data, so rd_wdata is only meaningful for rd!=0.
   always_comb begin
      diff    = '0;
      diff[0] = (ref_cap.pc != head.pc);
      diff[1] = (ref_cap.insn != head.insn);
      diff[2] = (ref_cap.rd_addr != head.rd_addr);
      diff[3] = (head.rd_addr != 5'd0) && (ref_cap.rd_wdata != head.rd_wdata);
      diff[4] = (ref_cap.trap != head.trap);
   end

   always_comb begin
      state_nxt     = state;
      set_err_order = 1'b0;
      set_timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               if (head.order != exp_order) begin
                  set_err_order = 1'b1;
                  state_nxt     = ERROR;
               end else begin
                  state_nxt = head.intr ? INTR : STEP;
               end
            end
         end
         INTR:  state_nxt = STEP;
         STEP:  state_nxt = WAIT;
         WAIT: begin
            if (rvfi.ref_valid_i) begin
               state_nxt = CMP;
            end else if (lag == '0) begin
               set_timeout = 1'b1;
               state_nxt   = ERROR;
            end
         end
         CMP:   state_nxt = (|diff) ? ERROR : IDLE;
         ERROR: state_nxt = ERROR;
         default: state_nxt = ERROR;
      endcase
      if (ovf) state_nxt = ERROR;
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         exp_order <= '0;
         lag       <= '0;
         ref_cap   <= '0;
         mismatch  <= 1'b0;
         mask      <= '0;
         err_order <= 1'b0;
         overflow  <= 1'b0;
         timeout   <= 1'b0;
         cnt       <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            exp_order <= exp_order + 64'd1;
         end
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
         // Down-counter: WAIT lasts MAX_LAG cycles before the terminal count fires.
         if (state == STEP) lag <= LW'(MAX_LAG - 1);
         else if (state == WAIT && lag != '0) lag <= lag - LW'(1);
         if (state == WAIT && rvfi.ref_valid_i)
            ref_cap <= '{pc:       rvfi.ref_pc_i,
                         insn:     rvfi.ref_insn_i,
                         rd_addr:  rvfi.ref_rd_addr_i,
                         rd_wdata: rvfi.ref_rd_wdata_i,
                         trap:     rvfi.ref_trap_i};
         if (state == CMP) begin
            if (|diff) begin
               mismatch <= 1'b1;
               mask     <= mask | diff;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end
         if (set_err_order) err_order <= 1'b1;
         if (set_timeout)   timeout   <= 1'b1;
         if (ovf)           overflow  <= 1'b1;
      end
   end

   assign rvfi.ref_step_o      = (state == STEP);
   assign rvfi.ref_intr_o      = (state == INTR);
   assign rvfi.ref_irq_o       = (state == INTR) ? head.irq : 32'd0;
   assign rvfi.ref_ready_o     = (state == WAIT);
   assign rvfi.mismatch_o      = mismatch;
   assign rvfi.mismatch_mask_o = mask;
   assign rvfi.err_order_o     = err_order;
   assign rvfi.overflow_o      = overflow;
   assign rvfi.timeout_o       = timeout;
   assign rvfi.compared_cnt_o  = cnt;
   assign rvfi.fifo_level_o    = level;
endmodule
